// File: rtl/idu_pipe.sv
`default_nettype none
// ============================================================================
// idu_pipe : single-entry RV32/64 decode stage (OP-IMM, LUI, AUIPC, EBREAK)
//            with a valid/ready handshake and a registered result.
// Rev 1.0
// ============================================================================
module idu_pipe #(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16,
  parameter int EN_SYS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic             out_src_pc,
  output logic             out_wen,
  output logic             out_ebreak,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_cnt,
  output logic             illegal_seen
);

  localparam logic [6:0]  C_OP_IMM = 7'b0010011;
  localparam logic [6:0]  C_LUI    = 7'b0110111;
  localparam logic [6:0]  C_AUIPC  = 7'b0010111;
  localparam logic [31:0] C_EBREAK = 32'h0010_0073;

  localparam logic [3:0] C_ALU_ADD  = 4'd0;
  localparam logic [3:0] C_ALU_SLL  = 4'd1;
  localparam logic [3:0] C_ALU_SLT  = 4'd2;
  localparam logic [3:0] C_ALU_SLTU = 4'd3;
  localparam logic [3:0] C_ALU_XOR  = 4'd4;
  localparam logic [3:0] C_ALU_SRL  = 4'd5;
  localparam logic [3:0] C_ALU_OR   = 4'd6;
  localparam logic [3:0] C_ALU_AND  = 4'd7;
  localparam logic [3:0] C_ALU_SRA  = 4'd13;

  logic signed [11:0] imm_i;
  logic signed [31:0] imm_u;
  logic               sh_zero;
  logic               sh_arith;
  logic [XLEN-1:0]    shamt;

  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu_op;
  logic            dec_src_pc, dec_wen, dec_ebreak, dec_illegal;

  logic             accept, handoff;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d;
  logic [4:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             src_pc_q, src_pc_d, wen_q, wen_d;
  logic             ebreak_q, ebreak_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_seen_q, ill_seen_d;

  assign imm_i = in_inst[31:20];
  assign imm_u = {in_inst[31:12], 12'b0};

  // RV64 widens shamt to 6 bits, so only inst[31:26] remain as funct bits
  always_comb begin
    if (XLEN == 64) begin
      sh_zero  = (in_inst[31:26] == 6'b000000);
      sh_arith = (in_inst[31:26] == 6'b010000);
      shamt    = XLEN'(in_inst[25:20]);
    end else begin
      sh_zero  = (in_inst[31:25] == 7'b0000000);
      sh_arith = (in_inst[31:25] == 7'b0100000);
      shamt    = XLEN'(in_inst[24:20]);
    end
  end

  always_comb begin
    dec_rd      = in_inst[11:7];
    dec_rs1     = in_inst[19:15];
    dec_rs2     = in_inst[24:20];
    dec_imm     = '0;
    dec_alu_op  = C_ALU_ADD;
    dec_src_pc  = 1'b0;
    dec_wen     = 1'b0;
    dec_ebreak  = 1'b0;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      C_OP_IMM: begin
        dec_imm = XLEN'(imm_i);
        dec_wen = 1'b1;
        case (in_inst[14:12])
          3'b000: dec_alu_op = C_ALU_ADD;
          3'b010: dec_alu_op = C_ALU_SLT;
          3'b011: dec_alu_op = C_ALU_SLTU;
          3'b100: dec_alu_op = C_ALU_XOR;
          3'b110: dec_alu_op = C_ALU_OR;
          3'b111: dec_alu_op = C_ALU_AND;
          3'b001: begin
            dec_imm     = shamt;
            dec_alu_op  = C_ALU_SLL;
            dec_illegal = !sh_zero;
          end
          default: begin
            dec_imm = shamt;
            if (sh_zero)       dec_alu_op  = C_ALU_SRL;
            else if (sh_arith) dec_alu_op  = C_ALU_SRA;
            else               dec_illegal = 1'b1;
          end
        endcase
      end
      C_LUI: begin
        dec_rs1 = 5'd0;
        dec_imm = XLEN'(imm_u);
        dec_wen = 1'b1;
      end
      C_AUIPC: begin
        dec_imm    = XLEN'(imm_u);
        dec_src_pc = 1'b1;
        dec_wen    = 1'b1;
      end
      default: begin
        if ((EN_SYS != 0) && (in_inst == C_EBREAK)) begin
          dec_ebreak = 1'b1;
          dec_rd     = 5'd0;
          dec_rs1    = 5'd0;
          dec_rs2    = 5'd0;
        end else begin
          dec_illegal = 1'b1;
        end
      end
    endcase
    // rs2 stays raw on illegal encodings; everything else is squashed
    if (dec_illegal) begin
      dec_rd     = 5'd0;
      dec_rs1    = 5'd0;
      dec_imm    = '0;
      dec_alu_op = C_ALU_ADD;
      dec_wen    = 1'b0;
      dec_src_pc = 1'b0;
      dec_ebreak = 1'b0;
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign handoff  = valid_q && out_ready && !flush;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    imm_d      = imm_q;
    alu_op_d   = alu_op_q;
    src_pc_d   = src_pc_q;
    wen_d      = wen_q;
    ebreak_d   = ebreak_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q;
    ill_seen_d = ill_seen_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      rd_d      = dec_rd;
      rs1_d     = dec_rs1;
      rs2_d     = dec_rs2;
      imm_d     = dec_imm;
      alu_op_d  = dec_alu_op;
      src_pc_d  = dec_src_pc;
      wen_d     = dec_wen;
      ebreak_d  = dec_ebreak;
      illegal_d = dec_illegal;
    end else if (handoff) begin
      valid_d = 1'b0;
    end
    if (handoff) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (illegal_q) ill_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      alu_op_q   <= '0;
      src_pc_q   <= 1'b0;
      wen_q      <= 1'b0;
      ebreak_q   <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
      ill_seen_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
      alu_op_q   <= alu_op_d;
      src_pc_q   <= src_pc_d;
      wen_q      <= wen_d;
      ebreak_q   <= ebreak_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
      ill_seen_q <= ill_seen_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_rd       = rd_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_imm      = imm_q;
  assign out_alu_op   = alu_op_q;
  assign out_src_pc   = src_pc_q;
  assign out_wen      = wen_q;
  assign out_ebreak   = ebreak_q;
  assign out_illegal  = illegal_q;
  assign dec_cnt      = cnt_q;
  assign illegal_seen = ill_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_idu_pipe.sv
`default_nettype none
// ============================================================================
// tb_idu_pipe : directed decode vectors plus stall, flush, reset and wrap runs.
// Rev 1.0
// ============================================================================
module tb_idu_pipe;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc, out_pc, out_imm;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic [3:0]       out_alu_op;
  logic             out_src_pc, out_wen, out_ebreak, out_illegal, illegal_seen;
  logic [CNT_W-1:0] dec_cnt;

  idu_pipe #(.XLEN(XLEN), .CNT_W(CNT_W), .EN_SYS(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_src_pc(out_src_pc), .out_wen(out_wen),
    .out_ebreak(out_ebreak), .out_illegal(out_illegal),
    .dec_cnt(dec_cnt), .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        src_pc, wen, ebreak, illegal;
  } vec_t;

  vec_t vecs[16];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_ill;

  localparam logic [31:0] I_ADDI  = 32'hFFF0_8293;
  localparam logic [31:0] I_SRAI  = 32'h4041_D193;
  localparam logic [31:0] I_BADSR = 32'h2041_D193;
  localparam logic [31:0] I_LUI   = 32'h1234_5537;
  localparam logic [31:0] I_AUIPC = 32'h1230_0397;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input logic [4:0] rd, rs1, rs2,
                              input logic [31:0] imm, input logic [3:0] op,
                              input logic src_pc, wen, ebreak, illegal);
    vec_t v;
    v.inst = inst; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.op = op;
    v.src_pc = src_pc; v.wen = wen; v.ebreak = ebreak; v.illegal = illegal;
    return v;
  endfunction

  initial begin
    //                inst          rd  rs1 rs2 imm           op  pc wen eb ill
    vecs[0]  = mk(I_ADDI,         5,  1, 31, 32'hFFFFFFFF, 0,  0, 1, 0, 0);
    vecs[1]  = mk(I_SRAI,         3,  3,  4, 32'h4,        13, 0, 1, 0, 0);
    vecs[2]  = mk(I_BADSR,        0,  0,  4, 32'h0,        0,  0, 0, 0, 1);
    vecs[3]  = mk(I_LUI,          10, 0,  3, 32'h12345000, 0,  0, 1, 0, 0);
    vecs[4]  = mk(I_AUIPC,        7,  0,  3, 32'h12300000, 0,  1, 1, 0, 0);
    vecs[5]  = mk(32'h0010_0073,  0,  0,  0, 32'h0,        0,  0, 0, 1, 0);
    vecs[6]  = mk(32'h0051_A113,  2,  3,  5, 32'h5,        2,  0, 1, 0, 0);
    vecs[7]  = mk(32'h8000_4093,  1,  0,  0, 32'hFFFFF800, 4,  0, 1, 0, 0);
    vecs[8]  = mk(32'h01F2_1213,  4,  4, 31, 32'd31,       1,  0, 1, 0, 0);
    vecs[9]  = mk(32'h0202_1213,  0,  0,  0, 32'h0,        0,  0, 0, 0, 1);
    vecs[10] = mk(32'h0013_D313,  6,  7,  1, 32'h1,        5,  0, 1, 0, 0);
    vecs[11] = mk(32'h7FF0_F013,  0,  1, 31, 32'h7FF,      7,  0, 1, 0, 0);
    vecs[12] = mk(32'h0014_3493,  9,  8,  1, 32'h1,        3,  0, 1, 0, 0);
    vecs[13] = mk(32'h0F01_6093,  1,  2, 16, 32'hF0,       6,  0, 1, 0, 0);
    vecs[14] = mk(32'h0020_81B3,  0,  0,  2, 32'h0,        0,  0, 0, 0, 1);
    vecs[15] = mk(32'h0000_0073,  0,  0,  0, 32'h0,        0,  0, 0, 0, 1);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    out_ready = 1'b0; exp_cnt = '0; exp_ill = 1'b0;

    #2;
    check("rst_valid", out_valid, 0);
    check("rst_cnt", dec_cnt, 0);
    check("rst_ill", illegal_seen, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", {out_rd, out_rs1, out_rs2, out_imm, out_alu_op, out_pc,
                       out_src_pc, out_wen, out_ebreak, out_illegal}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // flushed illegal entry must neither count nor set the sticky flag
    @(negedge clk);
    in_valid = 1'b1; in_inst = I_BADSR; in_pc = 32'h40;
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_illegal", {out_valid, out_illegal, in_ready}, 3'b110);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_cnt", dec_cnt, 0);
    check("flush_ill", illegal_seen, 0);

    // accept attempt blocked by flush in the same cycle
    in_valid = 1'b1; in_inst = I_ADDI; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_valid", out_valid, 0);
    check("flush_accept_cnt", dec_cnt, 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = 32'h8000_0000 + 32'(i * 4);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d", i),
            {out_valid, out_rd, out_rs1, out_rs2, out_imm, out_alu_op,
             out_src_pc, out_wen, out_ebreak, out_illegal, out_pc},
            {1'b1, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].op,
             vecs[i].src_pc, vecs[i].wen, vecs[i].ebreak, vecs[i].illegal,
             32'h8000_0000 + 32'(i * 4)});
      check($sformatf("vec%0d_cnt", i), dec_cnt, exp_cnt);
      check($sformatf("vec%0d_ill_seen", i), illegal_seen, exp_ill);
      exp_cnt = exp_cnt + 1'b1;
      if (vecs[i].illegal) exp_ill = 1'b1;
    end

    // back-to-back lui/auipc with the consumer stalled for three cycles
    @(negedge clk);
    check("drain_valid", out_valid, 0);
    check("drain_cnt", dec_cnt, exp_cnt);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = I_LUI; in_pc = 32'h100;
    @(negedge clk);
    in_inst = I_AUIPC; in_pc = 32'h104;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("stall_hold%0d", k), {out_valid, in_ready, out_imm, out_pc, out_rd},
            {1'b1, 1'b0, 32'h12345000, 32'h100, 5'd10});
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    check("second_entry", {out_valid, out_src_pc, out_imm, out_pc, out_rd},
          {1'b1, 1'b1, 32'h12300000, 32'h104, 5'd7});
    check("second_cnt", dec_cnt, exp_cnt);
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    check("both_done_valid", out_valid, 0);
    check("both_done_cnt", dec_cnt, exp_cnt);

    // asynchronous reset between edges while an entry is held
    out_ready = 1'b0; in_valid = 1'b1; in_inst = I_ADDI; in_pc = 32'h300;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {out_valid, in_ready, dec_cnt, illegal_seen, out_imm, out_pc},
          {1'b0, 1'b1, 4'd0, 1'b0, 32'h0, 32'h0});
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_inst = I_SRAI; in_pc = 32'h200; out_ready = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_accept", {out_valid, out_alu_op, out_imm, out_pc},
          {1'b1, 4'd13, 32'h4, 32'h200});
    check("post_rst_cnt", dec_cnt, 0);
    @(negedge clk);
    check("post_rst_handoff", {out_valid, dec_cnt}, {1'b0, 4'd1});

    // 17 handoffs at full throughput wrap the 4-bit counter to 1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_inst = I_ADDI; out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      in_pc = 32'(k);
    end
    check("stream_full", {out_valid, in_ready, out_pc}, {1'b1, 1'b1, 32'd15});
    check("wrap_pre", dec_cnt, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("wrap_cnt", {out_valid, dec_cnt}, {1'b0, 4'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
